// File: rtl/tisc_control.sv
// Fetch/decode/execute/writeback sequencer for the 8x8 register file.
// Fetches 16-bit instructions, runs an 8-bit ALU, and issues one write pulse per writing op.
module tisc_control #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_data,
  output logic               rf_en,
  output logic [RADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]  rf_write_data,
  output logic [RADDR_W-1:0] rf_read_addr_1,
  input  logic [DATA_W-1:0]  rf_read_data_1,
  output logic [RADDR_W-1:0] rf_read_addr_2,
  input  logic [DATA_W-1:0]  rf_read_data_2,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               illegal,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t               state;
  logic [PC_W-1:0]      pc;
  logic [INSTR_W-1:0]   ir;
  logic [DATA_W-1:0]    reg_a;
  logic [DATA_W-1:0]    reg_b;
  logic [DATA_W-1:0]    result;
  logic                 zf;
  logic                 cf;

  logic [3:0]           op;
  logic [RADDR_W-1:0]   rd;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_carry;
  logic                 flag_upd;
  logic                 op_illegal;

  assign op = ir[15:12];
  assign rd = ir[11:9];
  assign op_illegal = (op >= 4'hA) && (op <= 4'hE);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    flag_upd  = 1'b0;
    case (op)
      OP_ADD: begin
        {alu_carry, alu_res} = {1'b0, reg_a} + {1'b0, reg_b};
        flag_upd = 1'b1;
      end
      OP_SUB: begin
        alu_res   = reg_a - reg_b;
        alu_carry = (reg_a < reg_b);
        flag_upd  = 1'b1;
      end
      OP_AND: begin alu_res = reg_a & reg_b; flag_upd = 1'b1; end
      OP_OR:  begin alu_res = reg_a | reg_b; flag_upd = 1'b1; end
      OP_XOR: begin alu_res = reg_a ^ reg_b; flag_upd = 1'b1; end
      OP_MOV: alu_res = reg_a;
      OP_LDI: alu_res = DATA_W'(ir[7:0]);
      default: alu_res = '0;
    endcase
  end

  // Outputs are decoded from registered state; rst forces them all low so a
  // reset landing in WRITEBACK suppresses that cycle's register write.
  assign instr_req      = !rst && (state == S_FETCH);
  assign instr_addr     = rst ? RESET_PC : pc;
  assign rf_en          = !rst && (state == S_WRITEBACK);
  assign rf_write_addr  = rst ? '0 : rd;
  assign rf_write_data  = rst ? '0 : result;
  assign rf_read_addr_1 = rst ? '0 : ((op == OP_BEQZ) ? rd : ir[8:6]);
  assign rf_read_addr_2 = rst ? '0 : ir[5:3];
  assign zero_flag      = !rst && zf;
  assign carry_flag     = !rst && cf;
  assign illegal        = !rst && (state == S_EXECUTE) && op_illegal;
  assign halted         = !rst && (state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      reg_a  <= '0;
      reg_b  <= '0;
      result <= '0;
      zf     <= 1'b0;
      cf     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir    <= instr_data;
            pc    <= pc + PC_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          reg_a <= rf_read_data_1;
          reg_b <= rf_read_data_2;
          state <= S_EXECUTE;
        end
        S_EXECUTE: begin
          result <= alu_res;
          if (flag_upd) begin
            zf <= (alu_res == '0);
            cf <= alu_carry;
          end
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LDI:
              state <= S_WRITEBACK;
            OP_JMP: begin
              pc    <= PC_W'(ir[7:0]);
              state <= S_FETCH;
            end
            OP_BEQZ: begin
              if (reg_a == '0) pc <= PC_W'(ir[7:0]);
              state <= S_FETCH;
            end
            OP_HALT: state <= S_HALT;
            default: state <= S_FETCH;  // NOP and illegal opcodes
          endcase
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_tisc_control.sv
// Directed bench for tisc_control: small instruction memory and register file
// around the sequencer, writes checked against a hand-computed expected queue.
module tb_tisc_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        rf_en;
  logic [2:0]  rf_write_addr;
  logic [7:0]  rf_write_data;
  logic [2:0]  rf_read_addr_1;
  logic [7:0]  rf_read_data_1;
  logic [2:0]  rf_read_addr_2;
  logic [7:0]  rf_read_data_2;
  logic        zero_flag;
  logic        carry_flag;
  logic        illegal;
  logic        halted;

  logic        valid_en = 1'b0;
  logic [15:0] mem [256];
  logic [7:0]  rf  [8];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [26:0] exp_q [$];

  always #5 clk = ~clk;

  tisc_control dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req      (instr_req),
    .instr_addr     (instr_addr),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .rf_en          (rf_en),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_read_data_2 (rf_read_data_2),
    .zero_flag      (zero_flag),
    .carry_flag     (carry_flag),
    .illegal        (illegal),
    .halted         (halted)
  );

  assign instr_valid    = valid_en;
  assign instr_data     = mem[instr_addr];
  assign rf_read_data_1 = rf[rf_read_addr_1];
  assign rf_read_data_2 = rf[rf_read_addr_2];

  always @(posedge clk) if (rf_en) rf[rf_write_addr] <= rf_write_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: sample on the falling edge and score any write pulse as {cycle, addr, data}.
  task automatic tick();
    logic [26:0] e;
    @(negedge clk);
    cyc++;
    if (rf_en) begin
      if (exp_q.size() == 0) chk("rf_en_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("writeback", {5'd0, 16'(cyc), rf_write_addr, rf_write_data}, {5'd0, e});
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic push_wb(input int c, input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({16'(c), a, d});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_instr_req",  {31'd0, instr_req},  32'd0);
    chk("rst_instr_addr", {24'd0, instr_addr}, 32'd0);
    chk("rst_rf_en",      {31'd0, rf_en},      32'd0);
    chk("rst_halted",     {31'd0, halted},     32'd0);
    chk("rst_illegal",    {31'd0, illegal},    32'd0);
    chk("rst_flags",      {30'd0, zero_flag, carry_flag}, 32'd0);
    chk("rst_wr",         {21'd0, rf_write_addr, rf_write_data}, 32'd0);
    chk("rst_rd_addr",    {26'd0, rf_read_addr_1, rf_read_addr_2}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    // ALU program, illegal opcode, branches and pc wrap.
    clear_mem();
    mem[8'h00] = 16'h7205;  // LDI r1,5
    mem[8'h01] = 16'h7403;  // LDI r2,3
    mem[8'h02] = 16'h1650;  // ADD r3,r1,r2
    mem[8'h03] = 16'h2888;  // SUB r4,r2,r1
    mem[8'h04] = 16'h7AFF;  // LDI r5,0xFF
    mem[8'h05] = 16'h7C01;  // LDI r6,1
    mem[8'h06] = 16'h1F70;  // ADD r7,r5,r6
    mem[8'h07] = 16'hB000;  // illegal
    mem[8'h08] = 16'h9020;  // BEQZ r0,0x20 (taken)
    mem[8'h20] = 16'h9240;  // BEQZ r1,0x40 (not taken)
    mem[8'h21] = 16'h80FF;  // JMP 0xFF
    mem[8'hFF] = 16'h705A;  // LDI r0,0x5A
    valid_en = 1'b1;
    do_reset();
    push_wb(4,  3'd1, 8'h05);
    push_wb(8,  3'd2, 8'h03);
    push_wb(12, 3'd3, 8'h08);
    push_wb(16, 3'd4, 8'hFE);
    push_wb(20, 3'd5, 8'hFF);
    push_wb(24, 3'd6, 8'h01);
    push_wb(28, 3'd7, 8'h00);
    push_wb(44, 3'd0, 8'h5A);
    run_to(1);
    chk("first_req", {31'd0, instr_req}, 32'd1);
    run_to(2);
    chk("decode_req", {31'd0, instr_req}, 32'd0);
    run_to(12);
    chk("add_flags", {30'd0, zero_flag, carry_flag}, 32'b00);
    run_to(16);
    chk("sub_flags", {30'd0, zero_flag, carry_flag}, 32'b01);
    run_to(28);
    chk("add_wrap_flags", {30'd0, zero_flag, carry_flag}, 32'b11);
    run_to(30);
    chk("illegal_pre", {31'd0, illegal}, 32'd0);
    run_to(31);
    chk("illegal_pulse", {31'd0, illegal}, 32'd1);
    run_to(32);
    chk("illegal_post", {31'd0, illegal}, 32'd0);
    chk("illegal_flags", {30'd0, zero_flag, carry_flag}, 32'b11);
    chk("illegal_next_addr", {24'd0, instr_addr}, 32'h08);
    chk("illegal_next_req", {31'd0, instr_req}, 32'd1);
    run_to(35);
    chk("beqz_taken_addr", {24'd0, instr_addr}, 32'h20);
    run_to(38);
    chk("beqz_not_taken_addr", {24'd0, instr_addr}, 32'h21);
    run_to(41);
    chk("jmp_addr", {24'd0, instr_addr}, 32'hFF);
    run_to(45);
    chk("pc_wrap_addr", {24'd0, instr_addr}, 32'h00);
    chk("pc_wrap_req", {31'd0, instr_req}, 32'd1);
    chk("prog1_drained", exp_q.size(), 32'd0);

    // Delayed fetch response, then HALT.
    clear_mem();
    mem[8'h00] = 16'h7433;  // LDI r2,0x33
    mem[8'h01] = 16'hF000;  // HALT
    valid_en = 1'b0;
    do_reset();
    push_wb(7, 3'd2, 8'h33);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("wait_req", {31'd0, instr_req}, 32'd1);
      chk("wait_addr", {24'd0, instr_addr}, 32'h00);
      if (c == 4) valid_en = 1'b1;
    end
    tick();
    chk("wait_done_req", {31'd0, instr_req}, 32'd0);
    run_to(10);
    chk("pre_halt", {31'd0, halted}, 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, instr_req}, 32'd0);
    end
    chk("prog2_drained", exp_q.size(), 32'd0);

    // Reset landing in WRITEBACK must suppress the write.
    clear_mem();
    mem[8'h00] = 16'h7677;  // LDI r3,0x77
    do_reset();
    run_to(3);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("rst_wb_rf_en", {31'd0, rf_en}, 32'd0);
    chk("rst_wb_req", {31'd0, instr_req}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    tick();
    chk("rst_wb_r3_kept", {24'd0, rf[3]}, 32'h08);
    chk("post_rst_req", {31'd0, instr_req}, 32'd1);
    chk("post_rst_addr", {24'd0, instr_addr}, 32'h00);
    rst = 1'b1;
    chk("all_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
